// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding one shared, registered binary<->Gray converter.
// Each grant captures an operand, converts it and holds the result until the consumer accepts it.
module gray_conv_arbiter #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       mode,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic [IDW-1:0]        dout_id,
  input  logic                  dout_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]  op_q, op_d;
  logic              opmode_q, opmode_d;
  logic [IDW-1:0]    opid_q, opid_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [IDW-1:0]    dout_id_q, dout_id_d;
  logic              valid_q, valid_d;

  logic              found;
  logic [IDW-1:0]    win_idx;
  logic [IDW-1:0]    cand;
  int                idx;
  logic [WIDTH-1:0]  b2g, g2b;

  // First set request at or after ptr, wrapping past NREQ-1.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign b2g = op_q ^ (op_q >> 1);

  // Gray->binary bit i is the XOR of all Gray bits from i upward.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
      assign g2b[gi] = ^(op_q >> gi);
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    op_d      = op_q;
    opmode_d  = opmode_q;
    opid_d    = opid_q;
    gnt_d     = '0;
    dout_d    = dout_q;
    dout_id_d = dout_id_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_d           = din[int'(win_idx)*WIDTH +: WIDTH];
          opmode_d       = mode[win_idx];
          opid_d         = win_idx;
          gnt_d[win_idx] = 1'b1;
          ptr_d          = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
          state_d        = CONV;
        end
      end
      CONV: begin
        dout_d    = opmode_q ? g2b : b2g;
        dout_id_d = opid_q;
        valid_d   = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (dout_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      op_q      <= '0;
      opmode_q  <= 1'b0;
      opid_q    <= '0;
      gnt_q     <= '0;
      dout_q    <= '0;
      dout_id_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      op_q      <= op_d;
      opmode_q  <= opmode_d;
      opid_q    <= opid_d;
      gnt_q     <= gnt_d;
      dout_q    <= dout_d;
      dout_id_q <= dout_id_d;
      valid_q   <= valid_d;
    end
  end

  assign gnt        = gnt_q;
  assign dout       = dout_q;
  assign dout_id    = dout_id_q;
  assign dout_valid = valid_q;
  assign busy       = (state_q != IDLE);

endmodule
